// File: rtl/c17_bist_array.sv
// NCH copies of the c17 NAND network with a registered functional path and a logic-BIST engine
// (LFSR patterns, MISR compaction, golden compare). Define C17_FAULT_INJ_EN for stuck-at injection ports.
module c17_bist_array #(
    parameter int              NCH     = 4,
    parameter int              LW      = 16,
    parameter logic [LW-1:0]   TAPS    = 16'hB400,
    parameter logic [LW-1:0]   SEED    = 16'h0001,
    parameter int              PAT_CNT = 255,
    parameter logic [LW-1:0]   GOLDEN  = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5*NCH-1:0]   func_in,
    output logic [2*NCH-1:0]   func_out,
    input  logic               bist_start,
    input  logic               bist_abort,
    output logic               bist_busy,
    output logic               bist_done,
    output logic               bist_pass,
    output logic [LW-1:0]      signature
`ifdef C17_FAULT_INJ_EN
    ,
    input  logic               fi_en,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] fi_ch,
    input  logic [3:0]         fi_net,
    input  logic               fi_val
`endif
);

    localparam int            CW       = $clog2(PAT_CNT + 1);
    localparam logic [LW-1:0] SEED_EFF = (SEED == '0) ? LW'(1) : SEED;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_nxt;
    logic [LW-1:0]       lfsr, misr, misr_in, misr_nxt;
    logic [CW-1:0]       cnt;
    logic                pass;
    logic [5*NCH-1:0]    bist_pat;
    logic [2*NCH-1:0]    func_res, cut_out;
    logic [NCH-1:0]      inj;
    logic [3:0]          inj_net;
    logic                inj_val;
    logic                last, load, adv;

    function automatic logic [LW-1:0] step(input logic [LW-1:0] x);
        return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
    endfunction

    // Each net is replaced by the stuck value when selected, so the fault reaches all its fanout.
    function automatic logic [1:0] c17(input logic [4:0] g, input logic en,
                                       input logic [3:0] net, input logic val);
        logic g1, g2, g3, g4, g5, g8, g9, g12, g15, g16, g17;
        g1  = (en && net == 4'd0)  ? val : g[0];
        g2  = (en && net == 4'd1)  ? val : g[1];
        g3  = (en && net == 4'd2)  ? val : g[2];
        g4  = (en && net == 4'd3)  ? val : g[3];
        g5  = (en && net == 4'd4)  ? val : g[4];
        g8  = (en && net == 4'd5)  ? val : ~(g1 & g3);
        g9  = (en && net == 4'd6)  ? val : ~(g3 & g4);
        g12 = (en && net == 4'd7)  ? val : ~(g2 & g9);
        g15 = (en && net == 4'd8)  ? val : ~(g9 & g5);
        g16 = (en && net == 4'd9)  ? val : ~(g8 & g12);
        g17 = (en && net == 4'd10) ? val : ~(g12 & g15);
        return {g17, g16};
    endfunction

`ifdef C17_FAULT_INJ_EN
    assign inj_net = fi_net;
    assign inj_val = fi_val;
`else
    assign inj_net = 4'hF;
    assign inj_val = 1'b0;
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_ch
`ifdef C17_FAULT_INJ_EN
        assign inj[k] = fi_en && (int'(fi_ch) == k);
`else
        assign inj[k] = 1'b0;
`endif
        assign func_res[2*k +: 2] = c17(func_in[5*k +: 5], inj[k], inj_net, inj_val);
        assign cut_out[2*k +: 2]  = c17(bist_pat[5*k +: 5], inj[k], inj_net, inj_val);
    end

    // Pattern bits wrap around the LFSR; response bits fold into the MISR with XOR.
    always_comb begin
        bist_pat = '0;
        misr_in  = '0;
        for (int b = 0; b < 5*NCH; b++) bist_pat[b] = lfsr[b % LW];
        for (int j = 0; j < 2*NCH; j++) misr_in[j % LW] = misr_in[j % LW] ^ cut_out[j];
    end

    assign misr_nxt = step(misr) ^ misr_in;
    assign last     = (cnt == CW'(PAT_CNT - 1));
    assign load     = (state != RUN) && bist_start && !bist_abort;
    assign adv      = (state == RUN) && !bist_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bist_start && !bist_abort) state_nxt = RUN;
            RUN:     if (bist_abort) state_nxt = IDLE;
                     else if (last)  state_nxt = DONE;
            DONE:    if (bist_abort) state_nxt = IDLE;
                     else if (bist_start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bist_busy = (state == RUN);
        bist_done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr     <= SEED_EFF;
            misr     <= '0;
            cnt      <= '0;
            pass     <= 1'b0;
            func_out <= '0;
        end else begin
            if (state != RUN) func_out <= func_res;
            if (load) begin
                lfsr <= SEED_EFF;
                misr <= '0;
                cnt  <= '0;
                pass <= 1'b0;
            end else if (adv) begin
                misr <= misr_nxt;
                lfsr <= step(lfsr);
                cnt  <= cnt + CW'(1);
                if (last) pass <= (misr_nxt == GOLDEN);
            end
            if (bist_abort) pass <= 1'b0;
        end
    end

    assign bist_pass = pass;
    assign signature = misr;

endmodule

// File: tb/tb_c17_bist_array.sv
// Randomized bench for c17_bist_array: functional path and BIST runs checked against a
// behavioural net-list model and a pattern-by-pattern signature model.
module tb_c17_bist_array;

    localparam int            NCH     = 4;
    localparam int            LW      = 16;
    localparam logic [LW-1:0] TAPS    = 16'hB400;
    localparam logic [LW-1:0] SEED    = 16'h0001;
    localparam int            PAT_CNT = 255;

    // Nets in order G1..G5, G8, G9, G12, G15, G16, G17; a stuck net overrides its computed value.
    function automatic logic [1:0] model_c17(input logic [4:0] g, input int fnet, input logic fval);
        logic [10:0] n;
        n = '0;
        for (int i = 0; i < 11; i++) begin
            case (i)
                0, 1, 2, 3, 4: n[i] = g[i];
                5:       n[i] = !(n[0] && n[2]);
                6:       n[i] = !(n[2] && n[3]);
                7:       n[i] = !(n[1] && n[6]);
                8:       n[i] = !(n[6] && n[4]);
                9:       n[i] = !(n[5] && n[7]);
                default: n[i] = !(n[7] && n[8]);
            endcase
            if (i == fnet) n[i] = fval;
        end
        return {n[10], n[9]};
    endfunction

    function automatic logic [2*NCH-1:0] model_func(input logic [5*NCH-1:0] fin, input int fch,
                                                    input int fnet, input logic fval);
        logic [2*NCH-1:0] o;
        o = '0;
        for (int k = 0; k < NCH; k++)
            o[2*k +: 2] = model_c17(fin[5*k +: 5], (k == fch) ? fnet : -1, fval);
        return o;
    endfunction

    function automatic logic [LW-1:0] model_sig(input int npat, input int fch, input int fnet,
                                                input logic fval);
        logic [LW-1:0]    l, m, f;
        logic [5*NCH-1:0] p;
        logic [2*NCH-1:0] o;
        l = (SEED == 0) ? 1 : SEED;
        m = '0;
        for (int t = 0; t < npat; t++) begin
            p = '0;
            for (int b = 0; b < 5*NCH; b++) p[b] = l[b % LW];
            o = model_func(p, fch, fnet, fval);
            f = '0;
            for (int j = 0; j < 2*NCH; j++) f[j % LW] = f[j % LW] ^ o[j];
            m = (m >> 1) ^ (m[0] ? TAPS : '0) ^ f;
            l = (l >> 1) ^ (l[0] ? TAPS : '0);
        end
        return m;
    endfunction

    localparam logic [LW-1:0] GOLDEN_TB = model_sig(PAT_CNT, 0, -1, 1'b0);

    logic               clk, rst;
    logic [5*NCH-1:0]   func_in;
    logic [2*NCH-1:0]   func_out;
    logic               bist_start, bist_abort, bist_busy, bist_done, bist_pass;
    logic [LW-1:0]      signature;
`ifdef C17_FAULT_INJ_EN
    logic               fi_en;
    logic [1:0]         fi_ch;
    logic [3:0]         fi_net;
    logic               fi_val;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [2*NCH-1:0] exp_q[$];

    c17_bist_array #(
        .NCH(NCH), .LW(LW), .TAPS(TAPS), .SEED(SEED), .PAT_CNT(PAT_CNT), .GOLDEN(GOLDEN_TB)
    ) dut (
        .clk(clk), .rst(rst), .func_in(func_in), .func_out(func_out),
        .bist_start(bist_start), .bist_abort(bist_abort), .bist_busy(bist_busy),
        .bist_done(bist_done), .bist_pass(bist_pass), .signature(signature)
`ifdef C17_FAULT_INJ_EN
        , .fi_en(fi_en), .fi_ch(fi_ch), .fi_net(fi_net), .fi_val(fi_val)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_bist(input int glitch_at, output int busy_cycles,
                            output logic [5*NCH-1:0] fin0);
        fin0 = func_in;
        bist_start = 1'b1;
        @(posedge clk); #1;
        bist_start = 1'b0;
        busy_cycles = 0;
        while (bist_busy === 1'b1 && busy_cycles < 2000) begin
            busy_cycles++;
            bist_start = (busy_cycles == glitch_at);
            func_in = (5*NCH)'($urandom);
            @(posedge clk); #1;
        end
        bist_start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; func_in = '1; bist_start = 1'b0; bist_abort = 1'b0;
`ifdef C17_FAULT_INJ_EN
        fi_en = 1'b0; fi_ch = '0; fi_net = 4'hF; fi_val = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (func_out !== '0) begin n_fail++; $display("FAIL reset_func_out: got %h want 0", func_out); end
        n_cmp++; if (bist_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bist_busy); end
        n_cmp++; if (bist_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bist_done); end
        n_cmp++; if (bist_pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b want 0", bist_pass); end
        n_cmp++; if (signature !== '0) begin n_fail++; $display("FAIL reset_signature: got %h want 0", signature); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_functional;
        logic [2*NCH-1:0] exp;
        func_in = '1;
        @(posedge clk); #1;
        n_cmp++; if (func_out !== {NCH{2'b01}}) begin n_fail++; $display("FAIL func_ones: got %h want %h", func_out, {NCH{2'b01}}); end
        func_in = '0;
        @(posedge clk); #1;
        n_cmp++; if (func_out !== '0) begin n_fail++; $display("FAIL func_zeros: got %h want 0", func_out); end
        for (int i = 0; i < 24; i++) begin
            func_in = (5*NCH)'($urandom);
            exp_q.push_back(model_func(func_in, 0, -1, 1'b0));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_cmp++; if (func_out !== exp) begin n_fail++; $display("FAIL func_random: in %h got %h want %h", func_in, func_out, exp); end
        end
    endtask

    task automatic test_bist_run;
        int cyc;
        logic [5*NCH-1:0] fin0;
        logic [2*NCH-1:0] frozen;
        func_in = (5*NCH)'($urandom);
        run_bist(0, cyc, fin0);
        frozen = model_func(fin0, 0, -1, 1'b0);
        n_cmp++; if (cyc !== PAT_CNT) begin n_fail++; $display("FAIL run_busy_cycles: got %0d want %0d", cyc, PAT_CNT); end
        n_cmp++; if (bist_done !== 1'b1) begin n_fail++; $display("FAIL run_done: got %b want 1", bist_done); end
        n_cmp++; if (bist_busy !== 1'b0) begin n_fail++; $display("FAIL run_busy_after: got %b want 0", bist_busy); end
        n_cmp++; if (signature !== model_sig(PAT_CNT, 0, -1, 1'b0)) begin n_fail++; $display("FAIL run_signature: got %h want %h", signature, model_sig(PAT_CNT, 0, -1, 1'b0)); end
        n_cmp++; if (bist_pass !== 1'b1) begin n_fail++; $display("FAIL run_pass: got %b want 1", bist_pass); end
        n_cmp++; if (func_out !== frozen) begin n_fail++; $display("FAIL run_func_frozen: got %h want %h", func_out, frozen); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bist_done !== 1'b1 || signature !== GOLDEN_TB) begin n_fail++; $display("FAIL done_hold: done %b sig %h want 1 %h", bist_done, signature, GOLDEN_TB); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [5*NCH-1:0] fin0;
        logic [LW-1:0] sig1;
        sig1 = signature;
        run_bist($urandom_range(PAT_CNT - 1, 1), cyc, fin0);
        n_cmp++; if (cyc !== PAT_CNT) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want %0d", cyc, PAT_CNT); end
        n_cmp++; if (signature !== sig1 || signature !== GOLDEN_TB) begin n_fail++; $display("FAIL b2b_signature: got %h want %h", signature, GOLDEN_TB); end
        n_cmp++; if (bist_pass !== 1'b1 || bist_done !== 1'b1) begin n_fail++; $display("FAIL b2b_pass_done: got %b%b want 11", bist_pass, bist_done); end
    endtask

    task automatic abort_after(input int k, input logic with_start);
        int cyc;
        logic [5*NCH-1:0] fin0;
        bist_start = 1'b1;
        @(posedge clk); #1;
        bist_start = 1'b0;
        repeat (k) @(posedge clk);
        #1;
        bist_abort = 1'b1;
        bist_start = with_start;
        @(posedge clk); #1;
        bist_abort = 1'b0;
        bist_start = 1'b0;
        n_cmp++; if (bist_busy !== 1'b0 || bist_done !== 1'b0) begin n_fail++; $display("FAIL abort_state k=%0d: busy %b done %b want 00", k, bist_busy, bist_done); end
        n_cmp++; if (signature !== model_sig(k, 0, -1, 1'b0)) begin n_fail++; $display("FAIL abort_signature k=%0d: got %h want %h", k, signature, model_sig(k, 0, -1, 1'b0)); end
        @(posedge clk); #1;
        n_cmp++; if (bist_busy !== 1'b0 || bist_pass !== 1'b0) begin n_fail++; $display("FAIL abort_idle_hold: busy %b pass %b want 00", bist_busy, bist_pass); end
        run_bist(0, cyc, fin0);
        n_cmp++; if (cyc !== PAT_CNT || signature !== GOLDEN_TB) begin n_fail++; $display("FAIL abort_rerun: cycles %0d sig %h want %0d %h", cyc, signature, PAT_CNT, GOLDEN_TB); end
    endtask

    task automatic test_abort;
        abort_after(100, 1'b0);
        abort_after($urandom_range(PAT_CNT - 2, 1), 1'b1);
        bist_abort = 1'b1;
        bist_start = 1'b1;
        @(posedge clk); #1;
        bist_abort = 1'b0;
        bist_start = 1'b0;
        n_cmp++; if (bist_busy !== 1'b0 || bist_done !== 1'b0 || bist_pass !== 1'b0) begin n_fail++; $display("FAIL abort_wins_done: busy %b done %b pass %b want 000", bist_busy, bist_done, bist_pass); end
        n_cmp++; if (signature !== GOLDEN_TB) begin n_fail++; $display("FAIL abort_sig_hold: got %h want %h", signature, GOLDEN_TB); end
    endtask

    task automatic test_async_reset;
        int cyc;
        logic [5*NCH-1:0] fin0;
        func_in = '1;
        @(posedge clk); #1;
        bist_start = 1'b1;
        @(posedge clk); #1;
        bist_start = 1'b0;
        repeat (50) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (bist_busy !== 1'b0 || bist_done !== 1'b0 || bist_pass !== 1'b0) begin n_fail++; $display("FAIL arst_flags: busy %b done %b pass %b want 000", bist_busy, bist_done, bist_pass); end
        n_cmp++; if (signature !== '0 || func_out !== '0) begin n_fail++; $display("FAIL arst_data: sig %h func_out %h want 0 0", signature, func_out); end
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        run_bist(0, cyc, fin0);
        n_cmp++; if (cyc !== PAT_CNT || signature !== GOLDEN_TB || bist_pass !== 1'b1) begin n_fail++; $display("FAIL arst_rerun: cycles %0d sig %h pass %b want %0d %h 1", cyc, signature, bist_pass, PAT_CNT, GOLDEN_TB); end
    endtask

`ifdef C17_FAULT_INJ_EN
    task automatic test_fault;
        int cyc;
        logic [5*NCH-1:0] fin0;
        logic [2*NCH-1:0] exp;
        fi_en = 1'b1; fi_ch = 2'd0; fi_net = 4'd7; fi_val = 1'b0;
        run_bist(0, cyc, fin0);
        n_cmp++; if (signature !== model_sig(PAT_CNT, 0, 7, 1'b0)) begin n_fail++; $display("FAIL fault_signature: got %h want %h", signature, model_sig(PAT_CNT, 0, 7, 1'b0)); end
        n_cmp++; if (signature === GOLDEN_TB || bist_pass !== 1'b0) begin n_fail++; $display("FAIL fault_detect: sig %h pass %b golden %h", signature, bist_pass, GOLDEN_TB); end
        func_in = '1;
        @(posedge clk); #1;
        n_cmp++; if (func_out !== {{(NCH-1){2'b01}}, 2'b11}) begin n_fail++; $display("FAIL fault_func_ones: got %h want %h", func_out, {{(NCH-1){2'b01}}, 2'b11}); end
        for (int i = 0; i < 8; i++) begin
            fi_ch  = 2'($urandom_range(NCH - 1, 0));
            fi_net = 4'($urandom_range(15, 0));
            fi_val = 1'($urandom);
            func_in = (5*NCH)'($urandom);
            exp = model_func(func_in, int'(fi_ch), int'(fi_net), fi_val);
            @(posedge clk); #1;
            n_cmp++; if (func_out !== exp) begin n_fail++; $display("FAIL fault_func_random: ch %0d net %0d got %h want %h", fi_ch, fi_net, func_out, exp); end
        end
        fi_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_functional();
        test_bist_run();
        test_back_to_back();
        test_abort();
        test_async_reset();
`ifdef C17_FAULT_INJ_EN
        test_fault();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
